game_controller: RTL and testbench

//  FSM that sequences the memory-game Datapath by driving R1,R2,E1..E4,SEL from the status flags.

---
 rtl/game_controller_if.sv | 26 ++
 rtl/game_controller.sv | 147 ++++++++++++++
 tb/tb_game_controller.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_controller_if.sv
// Status flags and control strobes shared by the game controller and the Datapath.
// The controller takes the master side. The Datapath takes the slave side.
interface game_controller_if;
  logic end_FPGA;
  logic end_User;
  logic end_time;
  logic win;
  logic match;
  logic R1;
  logic R2;
  logic E1;
  logic E2;
  logic E3;
  logic E4;
  logic SEL;

  modport master (
    input  end_FPGA, end_User, end_time, win, match,
    output R1, R2, E1, E2, E3, E4, SEL
  );

  modport slave (
    output end_FPGA, end_User, end_time, win, match,
    input  R1, R2, E1, E2, E3, E4, SEL
  );
endinterface

// File: rtl/game_controller.sv
// Memory-game sequencer: setup, FPGA playback, then timed user entry. It drives the Datapath
// strobes, generates the game tick, and turns the ENTER key into one pulse per press.
module game_controller #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  input  logic          ENTER_N,
  game_controller_if.master bus
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [2:0] {
    StInit,
    StSetup,
    StSeq,
    StPlay,
    StCheck,
    StNext,
    StResult
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      tick_cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 enter_prev_q;
  logic                 enter_pulse_q;
  logic                 tick;

  logic r1, r2, e1, e2, e3, e4, sel;

  // The key idles high, so the chain resets to 1s. A press is seen only on a falling edge.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync_q        <= '1;
      enter_prev_q  <= 1'b1;
      enter_pulse_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], ENTER_N};
      enter_prev_q  <= sync_q[SYNC_STAGES-1];
      enter_pulse_q <= enter_prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = (tick_cnt_q == CntW'(TICK_CYCLES - 1));

  // Restart the tick period on every state change. The first tick then falls a full period
  // after entry.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      tick_cnt_q <= '0;
    end else if ((state_d != state_q) || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r1      = 1'b0;
    r2      = 1'b0;
    e1      = 1'b0;
    e2      = 1'b0;
    e3      = 1'b0;
    e4      = 1'b0;
    sel     = 1'b0;
    case (state_q)
      StInit: begin
        r1      = 1'b1;
        r2      = 1'b1;
        state_d = StSetup;
      end
      StSetup: begin
        if (enter_pulse_q) begin
          e1      = 1'b1;
          r2      = 1'b1;
          state_d = StSeq;
        end
      end
      StSeq: begin
        if (tick) begin
          if (bus.end_FPGA) begin
            r2      = 1'b1;
            state_d = StPlay;
          end else begin
            e3 = 1'b1;
          end
        end
      end
      StPlay: begin
        e2 = tick;
        // A timeout wins over a key press in the same cycle, so that entry is not captured.
        if (bus.end_time) begin
          state_d = StResult;
        end else if (enter_pulse_q) begin
          e4      = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!bus.match) begin
          state_d = StResult;
        end else if (bus.end_User) begin
          state_d = StNext;
        end else begin
          state_d = StPlay;
        end
      end
      StNext: begin
        if (bus.win) begin
          state_d = StResult;
        end else begin
          e1      = 1'b1;
          r2      = 1'b1;
          state_d = StSeq;
        end
      end
      StResult: begin
        sel = 1'b1;
        if (enter_pulse_q) begin
          state_d = StInit;
        end
      end
      default: state_d = StInit;
    endcase
  end

  assign bus.R1  = r1;
  assign bus.R2  = r2;
  assign bus.E1  = e1;
  assign bus.E2  = e2;
  assign bus.E3  = e3;
  assign bus.E4  = e4;
  assign bus.SEL = sel;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller with TICK_CYCLES=4 and SYNC_STAGES=2. Directed scenarios come
// first. Random games follow and are checked against a rule-level model of one game.
module tb_game_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enter_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] ob_e1, ob_e2, ob_e3, ob_e4, ob_r1, ob_r2, ob_sel;

  game_controller_if bus();

  game_controller #(
    .TICK_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .ENTER_N (enter_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // Presses the key in cycle 0 and releases it in cycle 'hold'. Bit k of each vector holds that
  // output as sampled in cycle k. If et_k >= 0, end_time is raised in cycle et_k.
  task automatic press_obs(input int hold, input int win, input int et_k);
    ob_e1 = '0; ob_e2 = '0; ob_e3 = '0; ob_e4 = '0; ob_r1 = '0; ob_r2 = '0; ob_sel = '0;
    for (int k = 0; k < win; k++) begin
      @(posedge clk); #1;
      if (k == 0) enter_n = 1'b0;
      if (k == hold) enter_n = 1'b1;
      if (k == et_k) bus.end_time = 1'b1;
      @(negedge clk);
      ob_e1[k] = bus.E1; ob_e2[k] = bus.E2; ob_e3[k] = bus.E3; ob_e4[k] = bus.E4;
      ob_r1[k] = bus.R1; ob_r2[k] = bus.R2; ob_sel[k] = bus.SEL;
    end
    enter_n = 1'b1;
  endtask

  // Starts in the cycle after E1. Raises end_FPGA once n E3 steps are seen. The cycle
  // indices are counted from the E1 cycle.
  task automatic run_seq(input int n, output logic [31:0] e3v, output int r2k);
    int seen;
    seen = 0;
    e3v  = '0;
    r2k  = -1;
    for (int k = 1; k <= 4 * (n + 1) + 6; k++) begin
      @(posedge clk); #1;
      if (seen == n) bus.end_FPGA = 1'b1;
      @(negedge clk);
      if (bus.E3) begin e3v[k] = 1'b1; seen++; end
      if (bus.R2) begin r2k = k; break; end
    end
    @(posedge clk); #1;
    bus.end_FPGA = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; enter_n = 1'b1;
    bus.end_FPGA = 1'b0; bus.end_User = 1'b0; bus.end_time = 1'b0;
    bus.win = 1'b0; bus.match = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] e3v;
    int r2k;
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if ({bus.R1, bus.R2, bus.SEL, bus.E1, bus.E2, bus.E3, bus.E4} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 1100000",
               {bus.R1, bus.R2, bus.SEL, bus.E1, bus.E2, bus.E3, bus.E4});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.R1 !== 1'b1) begin n_fail++; $display("FAIL reset_init_r1: got %b want 1", bus.R1); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({bus.R1, bus.R2, bus.SEL} !== 3'b000) begin
      n_fail++; $display("FAIL reset_setup: got %b want 000", {bus.R1, bus.R2, bus.SEL});
    end
    // Reach PLAY, then reset in the middle of a cycle.
    press_obs(4, 4, -1);
    run_seq(0, e3v, r2k);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.R1, bus.R2, bus.SEL, bus.E1, bus.E2, bus.E3, bus.E4} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_midplay: got %b want 1100000",
               {bus.R1, bus.R2, bus.SEL, bus.E1, bus.E2, bus.E3, bus.E4});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({bus.R1, bus.R2} !== 2'b00) begin
      n_fail++; $display("FAIL reset_midplay_setup: got %b want 00", {bus.R1, bus.R2});
    end
  endtask

  task automatic test_edge_detect();
    do_reset();
    press_obs(20, 24, -1);
    n_checks++;
    if (ob_e1 !== 32'h8) begin n_fail++; $display("FAIL edge_e1: got %h want %h", ob_e1, 32'h8); end
    // After E1 in cycle 3, SEQ ticks fall in cycles 7, 11, ... while end_FPGA stays low.
    n_checks++;
    if (ob_e3 !== 32'h0088_8880) begin
      n_fail++; $display("FAIL edge_seq_e3: got %h want %h", ob_e3, 32'h0088_8880);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] e3v;
    int r2k;
    logic [31:0] e2v;
    do_reset();
    press_obs(4, 4, -1);
    run_seq(2, e3v, r2k);
    n_checks++;
    if (e3v !== 32'h110) begin n_fail++; $display("FAIL seq_e3: got %h want %h", e3v, 32'h110); end
    n_checks++;
    if (r2k !== 12) begin n_fail++; $display("FAIL seq_r2_cycle: got %0d want 12", r2k); end
    // Time-counter enable in PLAY: one pulse per tick period.
    e2v = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      e2v[k] = bus.E2;
    end
    n_checks++;
    if (e2v !== 32'h44) begin n_fail++; $display("FAIL play_e2: got %h want %h", e2v, 32'h44); end
  endtask

  task automatic test_round_pass();
    logic [31:0] e3v;
    int r2k;
    do_reset();
    press_obs(4, 4, -1);
    run_seq(1, e3v, r2k);
    n_checks++;
    if (r2k !== 8) begin n_fail++; $display("FAIL pass_seq_r2: got %0d want 8", r2k); end
    bus.match = 1'b1; bus.end_User = 1'b0;
    press_obs(5, 8, -1);
    n_checks++;
    if (ob_e4 !== 32'h8) begin n_fail++; $display("FAIL pass_e4: got %h want %h", ob_e4, 32'h8); end
    n_checks++;
    if ({ob_e1, ob_sel} !== 64'h0) begin
      n_fail++; $display("FAIL pass_stay_play: got e1=%h sel=%h want 0", ob_e1, ob_sel);
    end
    bus.end_User = 1'b1;
    press_obs(5, 6, -1);
    n_checks++;
    if ({ob_e4, ob_e1, ob_r2} !== {32'h8, 32'h20, 32'h20}) begin
      n_fail++;
      $display("FAIL pass_next: got e4=%h e1=%h r2=%h want 8 20 20", ob_e4, ob_e1, ob_r2);
    end
    run_seq(0, e3v, r2k);
    n_checks++;
    if (r2k !== 4) begin n_fail++; $display("FAIL pass_next_seq_r2: got %0d want 4", r2k); end
  endtask

  task automatic test_lose();
    logic [31:0] e3v;
    int r2k;
    bus.match = 1'b0; bus.end_User = 1'b0;
    press_obs(5, 8, -1);
    n_checks++;
    if ({ob_e4, ob_sel} !== {32'h8, 32'hE0}) begin
      n_fail++; $display("FAIL lose_mismatch: got e4=%h sel=%h want 8 e0", ob_e4, ob_sel);
    end
    press_obs(5, 8, -1);
    n_checks++;
    if ({ob_r1, ob_sel} !== {32'h10, 32'h0F}) begin
      n_fail++; $display("FAIL lose_restart: got r1=%h sel=%h want 10 0f", ob_r1, ob_sel);
    end
    press_obs(4, 4, -1);
    run_seq(0, e3v, r2k);
    bus.match = 1'b1;
    press_obs(5, 8, 3);
    n_checks++;
    if ({ob_e4, ob_sel} !== {32'h0, 32'hF0}) begin
      n_fail++; $display("FAIL lose_timeout: got e4=%h sel=%h want 0 f0", ob_e4, ob_sel);
    end
  endtask

  task automatic test_win_restart();
    logic [31:0] e3v;
    int r2k;
    do_reset();
    press_obs(4, 4, -1);
    run_seq(0, e3v, r2k);
    bus.match = 1'b1; bus.end_User = 1'b1; bus.win = 1'b1;
    press_obs(5, 8, -1);
    n_checks++;
    if ({ob_e4, ob_e1, ob_sel} !== {32'h8, 32'h0, 32'hC0}) begin
      n_fail++;
      $display("FAIL win_result: got e4=%h e1=%h sel=%h want 8 0 c0", ob_e4, ob_e1, ob_sel);
    end
    press_obs(5, 8, -1);
    n_checks++;
    if ({ob_r1, ob_r2, ob_sel} !== {32'h10, 32'h10, 32'h0F}) begin
      n_fail++;
      $display("FAIL win_restart: got r1=%h r2=%h sel=%h want 10 10 0f", ob_r1, ob_r2, ob_sel);
    end
  endtask

  // Random games. The model follows the game rules: a mismatch loses at once. The last entry of
  // the final round wins. The last entry of any other round starts the next playback.
  task automatic test_random_games();
    logic [31:0] e3v, exp_e3, exp_e1, exp_sel;
    int r2k, rounds, n, m, wlen;
    bit done, mt, eu, w;
    do_reset();
    for (int g = 0; g < 8; g++) begin
      done   = 1'b0;
      rounds = $urandom_range(1, 3);
      press_obs($urandom_range(4, 6), 4, -1);
      n_checks++;
      if (ob_e1 !== 32'h8) begin
        n_fail++; $display("FAIL rnd_setup_e1 g%0d: got %h want 8", g, ob_e1);
      end
      for (int r = 1; r <= rounds && !done; r++) begin
        n = $urandom_range(0, 3);
        exp_e3 = '0;
        for (int i = 1; i <= n; i++) exp_e3[4*i] = 1'b1;
        run_seq(n, e3v, r2k);
        n_checks++;
        if (e3v !== exp_e3 || r2k !== 4 * (n + 1)) begin
          n_fail++;
          $display("FAIL rnd_seq g%0d r%0d: got e3=%h r2@%0d want e3=%h r2@%0d",
                   g, r, e3v, r2k, exp_e3, 4 * (n + 1));
        end
        m = $urandom_range(1, 3);
        for (int j = 0; j < m && !done; j++) begin
          mt = ($urandom_range(0, 5) != 0);
          eu = (j == m - 1);
          w  = (r == rounds);
          bus.match = mt; bus.end_User = eu; bus.win = w;
          exp_e1 = '0; exp_sel = '0; wlen = 8;
          if (!mt) begin
            exp_sel = 32'hE0; done = 1'b1;
          end else if (eu && w) begin
            exp_sel = 32'hC0; done = 1'b1;
          end else if (eu) begin
            exp_e1 = 32'h20; wlen = 6;
          end
          press_obs($urandom_range(4, 6), wlen, -1);
          n_checks++;
          if ({ob_e4, ob_e1, ob_sel} !== {32'h8, exp_e1, exp_sel}) begin
            n_fail++;
            $display("FAIL rnd_entry g%0d r%0d j%0d: got e4=%h e1=%h sel=%h want 8 %h %h",
                     g, r, j, ob_e4, ob_e1, ob_sel, exp_e1, exp_sel);
          end
        end
      end
      press_obs(5, 8, -1);
      n_checks++;
      if ({ob_r1, ob_sel} !== {32'h10, 32'h0F}) begin
        n_fail++; $display("FAIL rnd_restart g%0d: got r1=%h sel=%h want 10 0f", g, ob_r1, ob_sel);
      end
    end
  endtask

  initial begin
    bus.end_FPGA = 1'b0; bus.end_User = 1'b0; bus.end_time = 1'b0;
    bus.win = 1'b0; bus.match = 1'b0;
    test_reset();
    test_edge_detect();
    test_sequence();
    test_round_pass();
    test_lose();
    test_win_restart();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
